// File: rtl/mac_fifo_sequencer_if.sv
// Bus bundle between the MAC-FIFO sequencer and its environment.
// Optional perf counters appear when MAC_SEQ_PERF_CNT_EN is defined.
interface mac_fifo_sequencer_if #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        mem_address;
    logic                     mem_read;
    logic [COLS*DATA_W-1:0]   mem_readdata;
    logic                     mem_readdatavalid;
    logic                     mem_waitrequest;
    logic [ROWS:0]            fifo_wren;
    logic [DATA_W-1:0]        fifo_wdata;
    logic [ROWS:0]            fifo_full;
    logic [ROWS:0]            fifo_empty;
    logic                     fifo_rden;
    logic                     mac_clr;
    logic                     mac_en;
`ifdef MAC_SEQ_PERF_CNT_EN
    logic [31:0]              perf_cycles;
    logic [31:0]              perf_stalls;
`endif

    modport master (
        input  start, base_addr, mem_readdata, mem_readdatavalid,
        input  mem_waitrequest, fifo_full, fifo_empty,
        output busy, done, mem_address, mem_read,
        output fifo_wren, fifo_wdata, fifo_rden, mac_clr, mac_en
`ifdef MAC_SEQ_PERF_CNT_EN
        , output perf_cycles, perf_stalls
`endif
    );

    modport slave (
        output start, base_addr, mem_readdata, mem_readdatavalid,
        output mem_waitrequest, fifo_full, fifo_empty,
        input  busy, done, mem_address, mem_read,
        input  fifo_wren, fifo_wdata, fifo_rden, mac_clr, mac_en
`ifdef MAC_SEQ_PERF_CNT_EN
        , input perf_cycles, perf_stalls
`endif
    );
endinterface

// File: rtl/mac_fifo_sequencer.sv
// Sequencer: fetch A rows + B vector, unpack bytes into FIFOs, then pop/MAC.
// Optional macro MAC_SEQ_PERF_CNT_EN adds perf_cycles/perf_stalls counters.
module mac_fifo_sequencer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_fifo_sequencer_if.master bus
);
    localparam int WW = $clog2(ROWS + 1);
    localparam int EW = $clog2(COLS + 1);
    localparam logic [WW-1:0] W_LAST = WW'(ROWS);
    localparam logic [EW-1:0] E_LAST = EW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_COMPUTE, S_FLUSH, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [WW-1:0]          w_q, w_d;
    logic [EW-1:0]          e_q, e_d;
    logic [COLS*DATA_W-1:0] sh_q, sh_d;
    logic                   clr_q, clr_d;
    logic                   en_q;
    logic                   wr_ok;
    logic                   pop_ok;
    logic                   rd_c;
    logic                   rden_c;
    logic [ROWS:0]          wren_c;

    assign wr_ok  = !bus.fifo_full[w_q];
    assign pop_ok = !(|bus.fifo_empty);

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            w_q     <= '0;
            e_q     <= '0;
            sh_q    <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            w_q     <= w_d;
            e_q     <= e_d;
            sh_q    <= sh_d;
            clr_q   <= clr_d;
            en_q    <= rden_c;
        end
    end

    // Next-state and per-state outputs; e doubles as the pop counter.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        w_d     = w_q;
        e_d     = e_q;
        sh_d    = sh_q;
        clr_d   = 1'b0;
        rd_c    = 1'b0;
        rden_c  = 1'b0;
        wren_c  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    w_d     = '0;
                    e_d     = '0;
                    clr_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                rd_c = 1'b1;
                if (!bus.mem_waitrequest) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_readdatavalid) begin
                    sh_d    = bus.mem_readdata;
                    e_d     = '0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (wr_ok) begin
                    wren_c[w_q] = 1'b1;
                    sh_d        = sh_q >> DATA_W;
                    e_d         = e_q + EW'(1);
                    if (e_q == E_LAST) begin
                        e_d = '0;
                        if (w_q != W_LAST) begin
                            w_d     = w_q + WW'(1);
                            state_d = S_REQ;
                        end else begin
                            state_d = S_COMPUTE;
                        end
                    end
                end
            end
            S_COMPUTE: begin
                if (pop_ok) begin
                    rden_c = 1'b1;
                    e_d    = e_q + EW'(1);
                    if (e_q == E_LAST) begin
                        e_d     = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.mem_read    = rd_c;
    assign bus.mem_address = base_q + ADDR_W'(w_q);
    assign bus.fifo_wren   = wren_c;
    assign bus.fifo_wdata  = sh_q[DATA_W-1:0];
    assign bus.fifo_rden   = rden_c;
    assign bus.mac_clr     = clr_q;
    assign bus.mac_en      = en_q;

`ifdef MAC_SEQ_PERF_CNT_EN
    logic [31:0] pcyc_q;
    logic [31:0] pstl_q;
    logic        stall;

    assign stall = (state_q == S_REQ && bus.mem_waitrequest) ||
                   (state_q == S_WAIT) ||
                   (state_q == S_UNPACK && !wr_ok);

    // Saturating busy/stall counters, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcyc_q <= '0;
            pstl_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            pcyc_q <= '0;
            pstl_q <= '0;
        end else begin
            if (bus.busy && !(&pcyc_q)) pcyc_q <= pcyc_q + 32'd1;
            if (stall && !(&pstl_q))    pstl_q <= pstl_q + 32'd1;
        end
    end

    assign bus.perf_cycles = pcyc_q;
    assign bus.perf_stalls = pstl_q;
`else
    // Counters are absent in this build.
`endif
endmodule

// File: tb/tb_mac_fifo_sequencer.sv
// Scoreboard bench for mac_fifo_sequencer: memory model, full/empty and
// waitrequest injection, mid-job reset and back-to-back starts.
module tb_mac_fifo_sequencer;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;

    typedef struct {
        int         w;
        logic [7:0] b;
    } wr_t;

    logic clk;
    logic rst;

    mac_fifo_sequencer_if #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) bus ();

    mac_fifo_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wr_t         wq[$];
    logic [31:0] aq[$];

    int done_cnt = 0;
    int job_wr   = 0;
    int job_wr2  = 0;
    int pop_cnt  = 0;
    int clr_cnt  = 0;
    int rd_cnt   = 0;
    logic [31:0] cur_base = '0;

    bit wq_mode = 0;
    bit ff_mode = 0;
    bit em_mode = 0;
    int wq_cnt  = 0;
    int ff_cnt  = 0;
    int em_cnt  = 0;

    bit          pend_v = 0;
    int          pend_c = 0;
    logic [31:0] pend_a = '0;

    logic rst_d     = 1'b0;
    logic prev_rden = 1'b0;
    logic prev_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a, input int k);
        logic [31:0] v;
        v = (a * 32'd37 + 32'(k) * 32'd11 + 32'd3) ^ (a >> 3);
        return v[7:0];
    endfunction

    function automatic logic [COLS*DATA_W-1:0] mem_word(input logic [31:0] a);
        logic [COLS*DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < COLS; k++) r[k*DATA_W +: DATA_W] = mem_byte(a, k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Environment: memory, FIFO status and the checking monitor.
    initial begin
        bit wq_now, wq_chk, ff_now, em_now;
        int idx;
        bus.mem_readdata      = '0;
        bus.mem_readdatavalid = 1'b0;
        bus.mem_waitrequest   = 1'b0;
        bus.fifo_full         = '0;
        bus.fifo_empty        = '0;
        forever begin
            @(negedge clk);
            bus.mem_readdatavalid = 1'b0;
            bus.mem_readdata      = '0;
            if (pend_v) begin
                pend_c--;
                if (pend_c == 0) begin
                    bus.mem_readdatavalid = 1'b1;
                    bus.mem_readdata      = mem_word(pend_a);
                    pend_v                = 0;
                end
            end
            wq_now = 0;
            wq_chk = 0;
            if (wq_mode && !rst) begin
                if (wq_cnt == 0 && bus.mem_read &&
                    bus.mem_address == 32'h103) begin
                    wq_cnt = 1;
                    wq_now = 1;
                end else if (wq_cnt == 1 || wq_cnt == 2) begin
                    wq_cnt++;
                    wq_now = 1;
                    wq_chk = 1;
                end
            end
            bus.mem_waitrequest = wq_now;
            ff_now = ff_mode && !rst && job_wr2 == 3 && ff_cnt < 4;
            if (ff_now) ff_cnt++;
            bus.fifo_full = '0;
            bus.fifo_full[2] = ff_now;
            em_now = em_mode && !rst && pop_cnt == 3 && em_cnt < 2;
            if (em_now) em_cnt++;
            bus.fifo_empty = '0;
            bus.fifo_empty[ROWS] = em_now;

            #1;
            if (rst_d) begin
                chk("rst_outs", {bus.busy, bus.done, bus.mem_read,
                    bus.mac_clr, bus.mac_en, bus.fifo_rden,
                    |bus.fifo_wren, bus.mem_address != 0}, 0);
            end
            chk("mac_en", bus.mac_en, prev_rden);
            if (wq_chk) begin
                chk("wait_read", bus.mem_read, 1);
                chk("wait_addr", bus.mem_address, 32'h103);
            end
            if (ff_now) chk("full_nowr", bus.fifo_wren[2], 0);
            if (em_now) chk("empty_nord", bus.fifo_rden, 0);
            if (bus.mac_clr) begin
                clr_cnt++;
                chk("clr_addr", bus.mem_address, cur_base);
            end
            if (bus.mem_read && !bus.mem_waitrequest && !rst) begin
                rd_cnt++;
                if (aq.size() == 0) chk("rd_extra", bus.mem_address, 0);
                else chk("rd_addr", bus.mem_address, aq.pop_front());
                pend_v = 1;
                pend_c = 2;
                pend_a = bus.mem_address;
            end
            if (|bus.fifo_wren) begin
                wr_t e;
                chk("wr_onehot", $onehot(bus.fifo_wren), 1);
                idx = 0;
                for (int i = 0; i <= ROWS; i++) if (bus.fifo_wren[i]) idx = i;
                job_wr++;
                if (idx == 2) job_wr2++;
                if (wq.size() == 0) begin
                    chk("wr_extra", idx, 99);
                end else begin
                    e = wq.pop_front();
                    chk("wr_idx", idx, e.w);
                    chk("wr_data", bus.fifo_wdata, e.b);
                end
            end
            if (bus.fifo_rden) pop_cnt++;
            if (bus.done) begin
                chk("done_len", prev_done, 0);
                chk("pops", pop_cnt, COLS);
                chk("writes", job_wr, (ROWS + 1) * COLS);
                chk("reads", rd_cnt, ROWS + 1);
                chk("clr_cnt", clr_cnt, 1);
                chk("wq_left", wq.size(), 0);
                chk("aq_left", aq.size(), 0);
                done_cnt++;
            end
            if (!rst && bus.start && !bus.busy) begin
                cur_base = bus.base_addr;
                wq.delete();
                aq.delete();
                for (int w = 0; w <= ROWS; w++) begin
                    aq.push_back(cur_base + 32'(w));
                    for (int k = 0; k < COLS; k++)
                        wq.push_back('{w: w, b: mem_byte(cur_base + 32'(w), k)});
                end
                job_wr = 0; job_wr2 = 0; pop_cnt = 0; clr_cnt = 0; rd_cnt = 0;
                wq_cnt = 0; ff_cnt = 0; em_cnt = 0;
            end
            if (rst) begin
                wq.delete();
                aq.delete();
                pend_v = 0;
                job_wr = 0; job_wr2 = 0; pop_cnt = 0; clr_cnt = 0; rd_cnt = 0;
            end
            prev_rden = rst ? 1'b0 : bus.fifo_rden;
            prev_done = bus.done;
            rst_d     = rst;
        end
    end

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            tick();
            n++;
        end
        chk("job_done", done_cnt, target);
    endtask

    task automatic run_job(input logic [31:0] base);
        int t;
        t = done_cnt + 1;
        bus.base_addr = base;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        wait_done(t);
        tick();
    endtask

    initial begin
        int n;
        int t;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        run_job(32'h100);

        wq_mode = 1;
        run_job(32'h100);
        wq_mode = 0;

        ff_mode = 1;
        run_job(32'h100);
        ff_mode = 0;

        em_mode = 1;
        t = done_cnt + 1;
        bus.base_addr = 32'h2000;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        repeat (6) tick();
        bus.base_addr = 32'h5555;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        wait_done(t);
        em_mode = 0;
        tick();

        bus.base_addr = 32'h300;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        n = 0;
        while (job_wr < 10 && n < 500) begin
            tick();
            n++;
        end
        chk("rst_reach", job_wr >= 10, 1);
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        run_job(32'h300);

        t = done_cnt + 2;
        bus.base_addr = 32'h40;
        bus.start     = 1'b1;
        wait_done(t);
        bus.start     = 1'b0;
        repeat (4) tick();
        chk("idle_after", bus.busy, 0);
        chk("jobs", done_cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_fifo_sequencer.md
Name: mac_fifo_sequencer

Overview:
- Controller that sequences the MAC-FIFO datapath: fetches a ROWS x COLS matrix A plus one COLS-element vector B from memory over an Avalon-MM read master.
- Serializes each fetched word byte-by-byte into per-row input FIFOs, then pops all FIFOs in lockstep while enabling the MAC array.
- Sits between the top-level start/status logic and the FIFO+MAC datapath, replacing ad-hoc top-level state sequencing.

Parameters:
- ROWS, 8, number of A rows / MAC units; B FIFO is index ROWS.
- COLS, 8, elements per row; FIFO depth must be >= COLS.
- DATA_W, 8, element width.
- ADDR_W, 32, memory address width; one word per address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one job; sampled only in IDLE
- base_addr  in  ADDR_W  word address of A row 0; sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entering DONE
- mem_address  out  ADDR_W  Avalon read address
- mem_read  out  1  Avalon read request
- mem_readdata  in  COLS*DATA_W  read word; element 0 in bits [DATA_W-1:0]
- mem_readdatavalid  in  1  readdata valid
- mem_waitrequest  in  1  slave stall
- fifo_wren  out  ROWS+1  one-hot FIFO write enable
- fifo_wdata  out  DATA_W  byte broadcast to all FIFOs
- fifo_full  in  ROWS+1  per-FIFO full
- fifo_rden  out  1  broadcast pop to all ROWS+1 FIFOs
- mac_clr  out  1  clear MAC accumulators
- mac_en  out  1  MAC accumulate enable

Behaviour:
- Reset: all outputs 0, state IDLE, word index 0, element counter 0. A reset mid-job aborts immediately; an outstanding read is discarded.
- Word index w runs 0..ROWS. Word w loads to FIFO w, where index ROWS is B. Address is base_addr+w.
- IDLE: when start=1, latch base_addr, set w=0, assert mac_clr for 1 cycle, go to REQ.
- REQ: drive mem_read=1 and mem_address=base_addr+w. Hold both stable while mem_waitrequest=1. On the cycle with waitrequest=0, drop mem_read and go to WAIT.
- WAIT: on mem_readdatavalid=1, latch mem_readdata into the unpack shift register, set e=0, go to UNPACK. A readdatavalid seen while in REQ is ignored.
- UNPACK: fifo_wdata = element e; fifo_wren[w]=1 unless fifo_full[w]=1. If full, stall with no write and hold e. On each write, e++.
  - After write e=COLS-1: if w<ROWS then w++ and go to REQ; else go to COMPUTE.
- COMPUTE: fifo_rden=1 for exactly COLS cycles. mac_en is fifo_rden delayed 1 cycle, to match 1-cycle FIFO read latency. Suppress fifo_rden (hold the count) in any cycle where any fifo_empty bit is 1 (fifo_empty is an internal status input of width ROWS+1). After COLS pops, go to FLUSH.
- FLUSH: 1 cycle; the last mac_en is high here. Go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. busy falls on entry to IDLE.
- start is ignored while busy. start held high in IDLE after DONE begins a new job.
- Total reads: ROWS+1. Total FIFO writes: (ROWS+1)*COLS. Total pops: COLS.

Optional Feature:
- Macro: MAC_SEQ_PERF_CNT_EN.
- Enabled: adds outputs perf_cycles (32-bit) and perf_stalls (32-bit).
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts cycles where the state is REQ with waitrequest=1, WAIT, or UNPACK with full.
  - Both clear on accepted start and saturate at all-ones. Both hold their value after DONE.
- Disabled: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 5 cycles mid-UNPACK -> next cycle all outputs 0, busy=0; a following start runs a full clean job.
- Nominal: ROWS=8, COLS=8, base_addr=0x100, zero-wait memory with 2-cycle read latency.
  - Addresses 0x100..0x108 issued in order; 72 fifo_wren pulses, 8 per FIFO, bytes in element order.
  - 8 fifo_rden cycles; mac_en equals rden delayed 1 cycle; one done pulse.
- Waitrequest: hold waitrequest high for 3 cycles on address 0x103 -> mem_read and mem_address stay stable; no duplicate request.
- FIFO full: assert fifo_full[2] for 4 cycles during word 2 -> no wren[2] in those cycles; e held; remaining bytes written afterward, none lost.
- Empty stall: pulse fifo_empty[8] for 2 cycles during COMPUTE -> rden low for those 2 cycles; exactly 8 total pops.
- start ignored: pulse start while busy -> no effect; with start held high continuously -> back-to-back jobs, each preceded by a mac_clr pulse.
